mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Load/store sequencer between the CPU datapath and the 256-byte synchronous data memory.
- Accepts one byte or 16-bit halfword request at a time over a valid/ready handshake.
- Drives the memory's MemRead/MemWrite/address/data_in; captures data_out one cycle after each read strobe.
- Returns read data over a valid/ready response channel.
- Halfwords are two sequential byte accesses, little-endian.

Parameters:
ADDR_WIDTH, 8, memory address width; address arithmetic wraps modulo 2^ADDR_WIDTH

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept request (IDLE only)
req_write  in  1  1=store, 0=load
req_half  in  1  1=16-bit access, 0=byte access
req_addr  in  ADDR_WIDTH  byte address (halfword low byte)
req_wdata  in  16  store data; [7:0] only for byte stores
resp_valid  out  1  access complete; resp_rdata valid
resp_ready  in  1  consumer accepts response
resp_rdata  out  16  load data; byte loads zero-extended; stores return 0
MemRead  out  1  to memory read strobe
MemWrite  out  1  to memory write strobe
mem_address  out  ADDR_WIDTH  to memory address
mem_wdata  out  8  to memory data_in
mem_rdata  in  8  from memory data_out (valid the cycle after MemRead)

Behaviour:
- Reset (async, immediate): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, MemRead=0, MemWrite=0, mem_address=0, mem_wdata=0; latched request regs cleared.
- Memory-side outputs are decoded from registered state plus latched request only; no combinational path from req_* or mem_rdata to any output.
- States: IDLE, ACC0, ACC1, CAP, DONE.
- IDLE: req_ready=1. On req_valid at an edge: latch write/half/addr/wdata, clear rdata, go to ACC0. Requests are ignored in all other states (req_ready=0).
- ACC0: mem_address=addr, mem_wdata=wdata[7:0], MemRead=~write, MemWrite=write. Next state:
  - half → ACC1
  - read byte → CAP
  - write byte → DONE
- ACC1: mem_address=addr+1 (wraps: 0xFF+1=0x00), mem_wdata=wdata[15:8], strobe as in ACC0. A read captures mem_rdata into rdata[7:0] at this edge. Next state: read → CAP, write → DONE.
- CAP: no strobes. Captures mem_rdata into rdata[7:0] (byte) or rdata[15:8] (half). Next state: DONE.
- DONE: resp_valid=1; resp_rdata holds stable. Strobes are 0, mem_address/mem_wdata hold their last values. When resp_ready=1 at an edge, go to IDLE (resp_valid=0 next cycle).
- Latency, accept edge to first resp_valid cycle:
  - byte write: 2 cycles
  - half write: 3 cycles
  - byte read: 3 cycles
  - half read: 4 cycles
- Throughput: the next request is accepted no earlier than the cycle after the response handshake.
- MemRead and MemWrite are never both 1. Each strobe is high exactly one cycle per byte.
- Reset mid-operation: strobes drop immediately and the pending response is discarded. A half store interrupted after ACC0 leaves only the low byte written; this is accepted behaviour.
- resp_ready held low: stay in DONE indefinitely with outputs stable.
- resp_ready high before resp_valid: has no effect.

Test Plan:
- Byte write then read: store addr 0x10, data 0x5A. Expect MemWrite high 1 cycle with address 0x10, data 0x5A. Then load 0x10 → resp_rdata=0x005A, resp_valid 3 cycles after accept.
- Halfword round trip: store half 0x40 = 0xBEEF. Expect writes 0x40←0xEF then 0x41←0xBE on consecutive cycles. Load half 0x40 → 0xBEEF after 4 cycles.
- Wrap-around: store half 0xFF = 0x1234. Expect 0xFF←0x34, 0x00←0x12. Byte loads of 0xFF and 0x00 return 0x0034 and 0x0012.
- Backpressure: a load completes while resp_ready=0 for 5 cycles. resp_valid and resp_rdata stay stable, req_ready=0, a req_valid pulse is ignored (no strobes). Raising resp_ready → IDLE next cycle.
- Async reset during ACC1 of a half store to 0x20: MemWrite falls without a clock edge. Afterwards 0x20 holds the new low byte and 0x21 is unchanged. All outputs are at reset values; a new request is accepted normally.
- Back-to-back: requests held continuously. Check exactly one accept per response handshake and that MemRead and MemWrite are never asserted together.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Load/store sequencer between the CPU datapath and a synchronous byte-wide
// data memory. It accepts one byte or halfword request at a time and splits a
// halfword into two consecutive byte accesses, little-endian: the low byte goes
// to addr and the high byte to addr+1. It returns load data over a valid/ready
// response channel.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   req_valid      request present
//   req_ready      controller idle and able to accept a request
//   req_write      1 = store, 0 = load
//   req_half       1 = 16-bit access, 0 = byte access
//   req_addr       byte address (low byte of a halfword)
//   req_wdata      store data; only [7:0] is used for byte stores
//   resp_valid     access complete, resp_rdata valid
//   resp_ready     consumer accepts the response
//   resp_rdata     load data (byte loads zero-extended, stores return 0)
//   MemRead        memory read strobe
//   MemWrite       memory write strobe
//   mem_address    memory address
//   mem_wdata      memory write data
//   mem_rdata      memory read data, valid the cycle after MemRead
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_half,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [15:0]           resp_rdata,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC0 = 3'd1,
        ACC1 = 3'd2,
        CAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state;

    // Latched request. The low store byte goes straight to mem_wdata on accept,
    // so only the high byte needs to be kept.
    logic                  lat_write;
    logic                  lat_half;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [BYTE_W-1:0]     lat_wdata_hi;

    // Sequencer. Every output is a register loaded with the value that belongs
    // to the state being entered, so each output is valid during that state and
    // has no combinational path from any input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            lat_write    <= 1'b0;
            lat_half     <= 1'b0;
            lat_addr     <= '0;
            lat_wdata_hi <= '0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            MemRead      <= 1'b0;
            MemWrite     <= 1'b0;
            mem_address  <= '0;
            mem_wdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state        <= ACC0;
                        lat_write    <= req_write;
                        lat_half     <= req_half;
                        lat_addr     <= req_addr;
                        lat_wdata_hi <= req_wdata[DATA_W-1:BYTE_W];
                        resp_rdata   <= '0;
                        req_ready    <= 1'b0;
                        // First byte access is presented during ACC0.
                        MemRead      <= ~req_write;
                        MemWrite     <= req_write;
                        mem_address  <= req_addr;
                        mem_wdata    <= req_wdata[BYTE_W-1:0];
                    end
                end

                ACC0: begin
                    if (lat_half) begin
                        // Second byte: the strobe stays high for one more
                        // cycle, now pointing at the wrapped high address.
                        state       <= ACC1;
                        mem_address <= lat_addr + ADDR_WIDTH'(1);
                        mem_wdata   <= lat_wdata_hi;
                    end else begin
                        MemRead  <= 1'b0;
                        MemWrite <= 1'b0;
                        if (lat_write) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= CAP;
                        end
                    end
                end

                ACC1: begin
                    MemRead  <= 1'b0;
                    MemWrite <= 1'b0;
                    if (lat_write) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                    end else begin
                        // Read data for the low byte (strobed in ACC0) is on
                        // mem_rdata now.
                        resp_rdata[BYTE_W-1:0] <= mem_rdata;
                        state                  <= CAP;
                    end
                end

                CAP: begin
                    // The last read strobe was one cycle ago; its data lands in
                    // the high byte for halfwords, the low byte otherwise.
                    if (lat_half) begin
                        resp_rdata[DATA_W-1:BYTE_W] <= mem_rdata;
                    end else begin
                        resp_rdata[BYTE_W-1:0] <= mem_rdata;
                    end
                    state      <= DONE;
                    resp_valid <= 1'b1;
                end

                DONE: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    MemRead    <= 1'b0;
                    MemWrite   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed bench for mem_access_ctrl. It pairs the controller with a 256-byte
// synchronous memory model and checks latencies, data, and memory traffic.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam int unsigned AW = 8;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic          req_half;
    logic [AW-1:0] req_addr;
    logic [15:0]   req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [15:0]   resp_rdata;
    logic          MemRead;
    logic          MemWrite;
    logic [AW-1:0] mem_address;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_half   (req_half),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: preset on the first edge to mem[i] = i*7+3, then
    // writes on MemWrite and registered reads on MemRead. Logs every write.
    logic [7:0]  mem [256];
    logic [15:0] wlog [$];
    int          rd_count = 0;
    bit          init_done = 1'b0;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
            init_done <= 1'b1;
        end else begin
            if (MemWrite) begin
                mem[mem_address] <= mem_wdata;
                wlog.push_back({mem_address, mem_wdata});
            end
            if (MemRead) begin
                mem_rdata <= mem[mem_address];
                rd_count  <= rd_count + 1;
            end
        end
    end

    // Handshake monitor: counts accepts and responses, flags an accept while a
    // response is still outstanding, and flags both strobes high together.
    int accepts = 0;
    int hs = 0;
    int outstanding = 0;
    bit overlap = 1'b0;
    bit both_seen = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= 0;
        end else begin
            if (req_valid && req_ready) begin
                if (outstanding != 0) overlap <= 1'b1;
                outstanding <= 1;
                accepts     <= accepts + 1;
            end
            if (resp_valid && resp_ready) begin
                outstanding <= 0;
                hs          <= hs + 1;
            end
            if (MemRead && MemWrite) both_seen <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one request from a negedge and return #1 after its accept edge.
    task automatic send(input string tag, input logic w, input logic h,
                        input logic [7:0] a, input logic [15:0] wd);
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_half  = h;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Counts edges from the accept edge (as 1) up to the edge raising resp_valid.
    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Full transaction: request, latency/data check, immediate handshake.
    task automatic do_req(input string tag, input logic w, input logic h,
                          input logic [7:0] a, input logic [15:0] wd,
                          input int exp_lat, input logic [15:0] exp_rd);
        int lat;
        send(tag, w, h, a, wd);
        wait_resp(lat);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " rdata"}, 32'(resp_rdata), 32'(exp_rd));
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk({tag, " resp_valid drop"}, 32'(resp_valid), 32'd0);
        chk({tag, " idle ready"}, 32'(req_ready), 32'd1);
    endtask

    int wl0;
    int rd0;
    int acc0;
    int hs0;
    int lat;

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_half   = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst resp_rdata", 32'(resp_rdata), 32'd0);
        chk("rst strobes", 32'({MemRead, MemWrite}), 32'd0);
        chk("rst mem_address", 32'(mem_address), 32'd0);
        chk("rst mem_wdata", 32'(mem_wdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Byte write 0x10 <- 0x5A, then byte read back
        wl0 = wlog.size();
        do_req("bw", 1'b1, 1'b0, 8'h10, 16'h995A, 2, 16'h0000);
        chk("bw write count", 32'(wlog.size() - wl0), 32'd1);
        chk("bw write entry", 32'(wlog[wl0]), 32'h105A);
        rd0 = rd_count;
        wl0 = wlog.size();
        do_req("br", 1'b0, 1'b0, 8'h10, 16'h0000, 3, 16'h005A);
        chk("br read strobes", 32'(rd_count - rd0), 32'd1);
        chk("br no writes", 32'(wlog.size() - wl0), 32'd0);

        // Halfword round trip at 0x40
        wl0 = wlog.size();
        do_req("hw", 1'b1, 1'b1, 8'h40, 16'hBEEF, 3, 16'h0000);
        chk("hw write count", 32'(wlog.size() - wl0), 32'd2);
        chk("hw write lo", 32'(wlog[wl0]), 32'h40EF);
        chk("hw write hi", 32'(wlog[wl0 + 1]), 32'h41BE);
        rd0 = rd_count;
        do_req("hr", 1'b0, 1'b1, 8'h40, 16'h0000, 4, 16'hBEEF);
        chk("hr read strobes", 32'(rd_count - rd0), 32'd2);

        // Address wrap on halfword store at 0xFF
        wl0 = wlog.size();
        do_req("wrap hw", 1'b1, 1'b1, 8'hFF, 16'h1234, 3, 16'h0000);
        chk("wrap write lo", 32'(wlog[wl0]), 32'hFF34);
        chk("wrap write hi", 32'(wlog[wl0 + 1]), 32'h0012);
        do_req("wrap br ff", 1'b0, 1'b0, 8'hFF, 16'h0000, 3, 16'h0034);
        do_req("wrap br 00", 1'b0, 1'b0, 8'h00, 16'h0000, 3, 16'h0012);

        // Backpressure: byte load of 0x41 held in DONE for 5 cycles
        rd0 = rd_count;
        wl0 = wlog.size();
        send("bp", 1'b0, 1'b0, 8'h41, 16'h0000);
        wait_resp(lat);
        chk("bp latency", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = (i == 2);
            req_write = 1'b1;
            req_half  = 1'b0;
            req_addr  = 8'h30;
            req_wdata = 16'h7777;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            chk("bp resp_valid", 32'(resp_valid), 32'd1);
            chk("bp resp_rdata", 32'(resp_rdata), 32'h00BE);
            chk("bp req_ready", 32'(req_ready), 32'd0);
        end
        chk("bp read strobes", 32'(rd_count - rd0), 32'd1);
        chk("bp no writes", 32'(wlog.size() - wl0), 32'd0);
        chk("bp addr hold", 32'(mem_address), 32'h41);
        chk("bp strobes idle", 32'({MemRead, MemWrite}), 32'd0);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("bp release valid", 32'(resp_valid), 32'd0);
        chk("bp release ready", 32'(req_ready), 32'd1);

        // Asynchronous reset during ACC1 of a halfword store to 0x20
        send("arst", 1'b1, 1'b1, 8'h20, 16'hC3D4);
        chk("arst acc0 write", 32'(MemWrite), 32'd1);
        chk("arst acc0 addr", 32'(mem_address), 32'h20);
        chk("arst acc0 data", 32'(mem_wdata), 32'hD4);
        @(posedge clk);
        #1;
        chk("arst acc1 write", 32'(MemWrite), 32'd1);
        chk("arst acc1 addr", 32'(mem_address), 32'h21);
        chk("arst acc1 data", 32'(mem_wdata), 32'hC3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst MemWrite", 32'(MemWrite), 32'd0);
        chk("arst MemRead", 32'(MemRead), 32'd0);
        chk("arst req_ready", 32'(req_ready), 32'd1);
        chk("arst resp_valid", 32'(resp_valid), 32'd0);
        chk("arst resp_rdata", 32'(resp_rdata), 32'd0);
        chk("arst mem_address", 32'(mem_address), 32'd0);
        chk("arst mem_wdata", 32'(mem_wdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("arst mem 0x20", 32'(mem[8'h20]), 32'hD4);
        chk("arst mem 0x21", 32'(mem[8'h21]), 32'hEA);
        do_req("arst ld 20", 1'b0, 1'b0, 8'h20, 16'h0000, 3, 16'h00D4);
        do_req("arst ld 21", 1'b0, 1'b0, 8'h21, 16'h0000, 3, 16'h00EA);

        // Back-to-back half loads with req_valid and resp_ready held high:
        // accepts land every 5 edges, so 20 edges give 4 accepts and 4 responses.
        acc0 = accepts;
        hs0  = hs;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_half   = 1'b1;
        req_addr   = 8'h40;
        resp_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        chk("b2b accepts", 32'(accepts - acc0), 32'd4);
        chk("b2b responses", 32'(hs - hs0), 32'd4);
        chk("b2b overlap", 32'(overlap), 32'd0);
        chk("b2b idle", 32'(req_ready), 32'd1);
        chk("b2b resp_rdata", 32'(resp_rdata), 32'hBEEF);
        chk("strobes exclusive", 32'(both_seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
